hex_display_scheduler: RTL and testbench
========================================

Name: hex_display_scheduler

Overview:
- Sequences the four-digit 7-segment display (HEX3..HEX0) from a 16-bit packed BCD value (4 digits × 4 bits).
- A single shared BCD-to-7-segment decoder is time-shared across the four digit registers, one digit per step, under an FSM.
- A valid/ready load handshake accepts new frames; leading-zero blanking and per-digit non-BCD error flags are supported.
- Sits between any BCD producer (counter, switch capture, arithmetic unit) and the board HEX outputs.

Parameters:
- STEP_DIV, 1, clock cycles spent per digit step (≥1); paces the sweep.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  requester has a frame on load_data
- load_data  input  16  packed BCD: [3:0]=digit0 (HEX0) … [15:12]=digit3 (HEX3)
- blank_lz  input  1  sampled with load; 1 = blank leading zeros
- load_ready  output  1  scheduler can accept a frame
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse, frame fully written
- err_digit  output  4  bit k=1: digit k of current frame was non-BCD (>9)
- HEX0, HEX1, HEX2, HEX3  output  7 each  registered active-low segments, bit0=a … bit6=g

Behaviour:
- Reset: HEX0..HEX3=7'b1111111, load_ready=1, busy=0, done=0, err_digit=0, state=IDLE, idx=0, divcnt=0. Reset mid-sweep aborts the frame, blanks all digits and discards the shadow.
- Decoder (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10–15=1111111 (blank).
- States:
  - IDLE: load_ready=1.
  - SCAN: busy=1.
  - DONE: done=1.
  - load_ready=0 in SCAN and DONE.
- IDLE → SCAN on load_valid & load_ready (edge E0):
  - capture load_data and blank_lz into shadow registers;
  - clear err_digit; idx=0; divcnt=0.
  - HEX outputs keep their old frame until overwritten.
- SCAN:
  - divcnt increments each cycle.
  - When divcnt==STEP_DIV-1: write decode(shadow digit idx) to HEX[idx]; set err_digit[idx] if the digit is >9; divcnt=0; idx++.
  - After writing idx=3, go to DONE.
  - HEXk is written at edge E0+(k+1)·STEP_DIV.
- DONE: lasts one cycle, then IDLE. load_ready is low for 4·STEP_DIV+1 cycles per frame.
- Leading-zero blanking (blank_lz=1): digit k (k=1..3) outputs 1111111 if it and all higher digits are 0. Digit0 is never blanked, so 0000 shows "0".
- Non-BCD digits:
  - A non-BCD digit counts as nonzero for blanking purposes.
  - It is still written as blank and flagged.
- load_valid during SCAN/DONE is not accepted. The requester must hold load_valid/load_data. No queueing, no drop flag.
- err_digit holds until the next accepted load or reset.
- Simultaneous load_valid and reset: reset wins; nothing is captured.
- STEP_DIV=1: divcnt is constant 0, and one digit is written per cycle.

Test Plan:
- Reset, STEP_DIV=1 → all HEX=1111111, load_ready=1, busy=0, done=0, err_digit=0.
- Load 16'h1234, blank_lz=0, accepted at E0:
  - HEX0=0011001 at E1, HEX1=0110000 at E2, HEX2=0100100 at E3, HEX3=1111001 at E4.
  - done=1 for the single cycle after E4; load_ready=1 after E5.
- Load 16'h0070, blank_lz=1:
  - HEX3=HEX2=1111111, HEX1=1111000, HEX0=1000000.
  - Load 16'h0000, blank_lz=1 → only HEX0=1000000 lit.
- Load 16'h9A05 → HEX3=0010000, HEX2=1111111, HEX1=1000000, HEX0=0010010, err_digit=4'b0100.
  - Next load 16'h0001 clears err_digit at acceptance.
- STEP_DIV=4: load 16'h5678, and hold load_valid with 16'h1111 during SCAN.
  - HEX writes at E4/E8/E12/E16.
  - Second frame accepted only after DONE and is written correctly.
- Assert reset at E2 of a STEP_DIV=1 sweep of 16'h8888 → next cycle all HEX=1111111, IDLE, load_ready=1; no later HEX writes.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// ============================================================================
// Module  : hex_display_scheduler
// Brief   : Time-shares one BCD-to-7-segment decoder across HEX0..HEX3,
//           writing one digit per STEP_DIV cycles after a frame is loaded.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display_scheduler #(
  parameter int STEP_DIV = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        blank_lz,
  output logic        load_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  err_digit,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam int c_DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);
  localparam logic [6:0] c_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_DIV_W-1:0] r_divcnt;
  logic [1:0]         r_idx;
  logic [15:0]        r_shadow;
  logic               r_blank_lz;
  logic [3:0]         r_err;
  logic [6:0]         r_hex0, r_hex1, r_hex2, r_hex3;

  logic               w_accept;
  logic               w_step;
  logic [3:0]         w_digit;
  logic               w_upper_zero;
  logic               w_bad;
  logic [6:0]         w_seg;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_accept = load_valid && (r_state == IDLE);
  assign w_step   = (r_state == SCAN) && (r_divcnt == c_DIV_LAST);
  assign w_digit  = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_bad    = (w_digit > 4'd9);

  // Digit k is a leading zero only if it and every higher digit are zero;
  // a non-BCD nibble is nonzero, so it stops blanking below it.
  always_comb begin
    w_upper_zero = 1'b0;
    case (r_idx)
      2'd1:    w_upper_zero = (r_shadow[15:4]  == 12'd0);
      2'd2:    w_upper_zero = (r_shadow[15:8]  == 8'd0);
      2'd3:    w_upper_zero = (r_shadow[15:12] == 4'd0);
      default: w_upper_zero = 1'b0;
    endcase
  end

  assign w_seg = (r_blank_lz && w_upper_zero) ? c_BLANK : f_decode(w_digit);

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (w_step && (r_idx == 2'd3)) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_divcnt   <= '0;
      r_idx      <= 2'd0;
      r_shadow   <= 16'd0;
      r_blank_lz <= 1'b0;
      r_err      <= 4'd0;
      r_hex0     <= c_BLANK;
      r_hex1     <= c_BLANK;
      r_hex2     <= c_BLANK;
      r_hex3     <= c_BLANK;
    end else if (w_accept) begin
      r_shadow   <= load_data;
      r_blank_lz <= blank_lz;
      r_err      <= 4'd0;
      r_idx      <= 2'd0;
      r_divcnt   <= '0;
    end else if (r_state == SCAN) begin
      if (w_step) begin
        r_divcnt     <= '0;
        r_idx        <= r_idx + 2'd1;
        r_err[r_idx] <= w_bad;
        case (r_idx)
          2'd0:    r_hex0 <= w_seg;
          2'd1:    r_hex1 <= w_seg;
          2'd2:    r_hex2 <= w_seg;
          default: r_hex3 <= w_seg;
        endcase
      end else begin
        r_divcnt <= r_divcnt + c_DIV_W'(1);
      end
    end
  end

  assign err_digit = r_err;
  assign HEX0      = r_hex0;
  assign HEX1      = r_hex1;
  assign HEX2      = r_hex2;
  assign HEX3      = r_hex3;

endmodule

`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
// ============================================================================
// Module  : tb_hex_display_scheduler
// Brief   : Scoreboard bench for hex_display_scheduler at STEP_DIV=1 and 4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_display_scheduler;

  typedef struct packed {
    logic [6:0] h3;
    logic [6:0] h2;
    logic [6:0] h1;
    logic [6:0] h0;
    logic [3:0] err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, v1, b1, rdy1, busy1, done1;
  logic [15:0] d1;
  logic [3:0]  err1;
  logic [6:0]  h1_0, h1_1, h1_2, h1_3;

  logic        rst4, v4, b4, rdy4, busy4, done4;
  logic [15:0] d4;
  logic [3:0]  err4;
  logic [6:0]  h4_0, h4_1, h4_2, h4_3;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q4[$];

  hex_display_scheduler #(.STEP_DIV(1)) dut1 (
    .CLOCK_50(clk), .reset(rst1), .load_valid(v1), .load_data(d1), .blank_lz(b1),
    .load_ready(rdy1), .busy(busy1), .done(done1), .err_digit(err1),
    .HEX0(h1_0), .HEX1(h1_1), .HEX2(h1_2), .HEX3(h1_3)
  );

  hex_display_scheduler #(.STEP_DIV(4)) dut4 (
    .CLOCK_50(clk), .reset(rst4), .load_valid(v4), .load_data(d4), .blank_lz(b4),
    .load_ready(rdy4), .busy(busy4), .done(done4), .err_digit(err4),
    .HEX0(h4_0), .HEX1(h4_1), .HEX2(h4_2), .HEX3(h4_3)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] d, input logic blz);
    exp_t       e;
    logic [6:0] s [4];
    logic       nz;
    logic [3:0] nib;
    nz    = 1'b0;
    e.err = 4'd0;
    for (int k = 3; k >= 0; k--) begin
      nib = d[k*4 +: 4];
      if (nib != 4'd0) nz = 1'b1;
      if (nib > 4'd9) begin
        e.err[k] = 1'b1;
        s[k]     = 7'b1111111;
      end else if (blz && (k != 0) && !nz) begin
        s[k] = 7'b1111111;
      end else begin
        s[k] = seg_of(nib);
      end
    end
    e.h3 = s[3];
    e.h2 = s[2];
    e.h1 = s[1];
    e.h0 = s[0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completed frames are compared against the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (done1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL frame1_unexpected_done got done=1 exp no pending frame");
        end else begin
          e = q1.pop_front();
          if ({h1_3, h1_2, h1_1, h1_0, err1} !== e) begin
            errors++;
            $display("FAIL frame1 got %h exp %h", {h1_3, h1_2, h1_1, h1_0, err1}, e);
          end
        end
      end
      if (done4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL frame4_unexpected_done got done=1 exp no pending frame");
        end else begin
          e = q4.pop_front();
          if ({h4_3, h4_2, h4_1, h4_0, err4} !== e) begin
            errors++;
            $display("FAIL frame4 got %h exp %h", {h4_3, h4_2, h4_1, h4_0, err4}, e);
          end
        end
      end
    end
  end

  task automatic wait_ready1(input int limit);
    int n = 0;
    while (!rdy1 && n < limit) begin
      tick();
      n++;
    end
    if (!rdy1) begin
      checks++;
      errors++;
      $display("FAIL ready1_timeout got ready=0 exp ready=1 within %0d cycles", limit);
    end
  endtask

  task automatic wait_ready4(input int limit);
    int n = 0;
    while (!rdy4 && n < limit) begin
      tick();
      n++;
    end
    if (!rdy4) begin
      checks++;
      errors++;
      $display("FAIL ready4_timeout got ready=0 exp ready=1 within %0d cycles", limit);
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (q1.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d exp 0/0", q1.size(), q4.size());
    end
    tick();
  endtask

  // Returns just after the acceptance edge E0.
  task automatic send1(input logic [15:0] d, input logic blz);
    wait_ready1(50);
    v1 = 1'b1;
    d1 = d;
    b1 = blz;
    tick();
    q1.push_back(model(d, blz));
    v1 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    v1 = 1'b0; v4 = 1'b0; d1 = 16'd0; d4 = 16'd0; b1 = 1'b0; b4 = 1'b0;
    tick(); tick();
    rst1 = 1'b0; rst4 = 1'b0;
    tick();
    checks++;
    if ({h1_3, h1_2, h1_1, h1_0, rdy1, busy1, done1, err1} !== {28'hFFFFFFF, 3'b100, 4'd0}) begin
      errors++;
      $display("FAIL reset1 got %h exp %h", {h1_3, h1_2, h1_1, h1_0, rdy1, busy1, done1, err1},
               {28'hFFFFFFF, 3'b100, 4'd0});
    end
    checks++;
    if ({h4_3, h4_2, h4_1, h4_0, rdy4, busy4, done4, err4} !== {28'hFFFFFFF, 3'b100, 4'd0}) begin
      errors++;
      $display("FAIL reset4 got %h exp %h", {h4_3, h4_2, h4_1, h4_0, rdy4, busy4, done4, err4},
               {28'hFFFFFFF, 3'b100, 4'd0});
    end
  endtask

  task automatic test_timing();
    send1(16'h1234, 1'b0);
    checks++;
    if ({rdy1, busy1} !== 2'b01) begin
      errors++; $display("FAIL e0_flags got rdy/busy=%b exp 01", {rdy1, busy1});
    end
    tick();
    checks++;
    if ({h1_0, h1_1} !== {7'b0011001, 7'b1111111}) begin
      errors++; $display("FAIL e1_hex got %b %b exp 0011001 1111111", h1_0, h1_1);
    end
    tick();
    checks++;
    if (h1_1 !== 7'b0110000) begin
      errors++; $display("FAIL e2_hex1 got %b exp 0110000", h1_1);
    end
    tick();
    checks++;
    if (h1_2 !== 7'b0100100) begin
      errors++; $display("FAIL e3_hex2 got %b exp 0100100", h1_2);
    end
    tick();
    checks++;
    if ({h1_3, done1, rdy1} !== {7'b1111001, 2'b10}) begin
      errors++; $display("FAIL e4 got hex3=%b done=%b rdy=%b exp 1111001 1 0", h1_3, done1, rdy1);
    end
    tick();
    checks++;
    if ({done1, rdy1} !== 2'b01) begin
      errors++; $display("FAIL e5 got done=%b rdy=%b exp 0 1", done1, rdy1);
    end
  endtask

  task automatic test_blanking();
    send1(16'h0070, 1'b1);
    drain(40);
    checks++;
    if ({h1_3, h1_2, h1_1, h1_0} !== {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}) begin
      errors++; $display("FAIL blank_0070 got %b %b %b %b", h1_3, h1_2, h1_1, h1_0);
    end
    send1(16'h0000, 1'b1);
    send1(16'h0A00, 1'b1);
    send1(16'h0000, 1'b0);
    drain(40);
  endtask

  task automatic test_err();
    send1(16'h9A05, 1'b0);
    drain(40);
    checks++;
    if ({err1, h1_2} !== {4'b0100, 7'b1111111}) begin
      errors++; $display("FAIL err_9a05 got err=%b hex2=%b exp 0100 1111111", err1, h1_2);
    end
    send1(16'h0001, 1'b0);
    checks++;
    if (err1 !== 4'd0) begin
      errors++; $display("FAIL err_clear got %b exp 0000", err1);
    end
    drain(40);
  endtask

  task automatic test_back_to_back();
    int ready_bad = 0;
    wait_ready4(50);
    v4 = 1'b1; d4 = 16'h5678; b4 = 1'b0;
    tick();
    q4.push_back(model(16'h5678, 1'b0));
    d4 = 16'h1111;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (rdy4) ready_bad++;
      if (i == 3) begin
        checks++;
        if (h4_0 !== 7'b1111111) begin
          errors++; $display("FAIL div4_e3 got %b exp 1111111", h4_0);
        end
      end
      if (i == 4 || i == 8 || i == 12 || i == 16) begin
        checks++;
        if ({h4_3, h4_2, h4_1, h4_0} !== {(i >= 16) ? 7'b0010010 : 7'b1111111,
                                          (i >= 12) ? 7'b0000010 : 7'b1111111,
                                          (i >= 8)  ? 7'b1111000 : 7'b1111111,
                                          7'b0000000}) begin
          errors++; $display("FAIL div4_e%0d got %b %b %b %b", i, h4_3, h4_2, h4_1, h4_0);
        end
      end
    end
    checks++;
    if (ready_bad != 0 || done4 !== 1'b1) begin
      errors++; $display("FAIL div4_hold got ready_high=%0d done=%b exp 0 1", ready_bad, done4);
    end
    tick();
    checks++;
    if ({rdy4, busy4} !== 2'b10) begin
      errors++; $display("FAIL div4_e17 got rdy/busy=%b exp 10", {rdy4, busy4});
    end
    tick();
    q4.push_back(model(16'h1111, 1'b0));
    v4 = 1'b0;
    checks++;
    if ({rdy4, busy4} !== 2'b01) begin
      errors++; $display("FAIL div4_second_accept got rdy/busy=%b exp 01", {rdy4, busy4});
    end
    drain(100);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send1(16'h8888, 1'b0);
    tick();
    checks++;
    if (h1_0 !== 7'b0000000) begin
      errors++; $display("FAIL mid_e1 got %b exp 0000000", h1_0);
    end
    rst1 = 1'b1;
    tick();
    void'(q1.pop_back());
    checks++;
    if ({h1_3, h1_2, h1_1, h1_0, rdy1, busy1, done1} !== {28'hFFFFFFF, 3'b100}) begin
      errors++; $display("FAIL mid_reset got %h exp %h", {h1_3, h1_2, h1_1, h1_0, rdy1, busy1, done1},
                         {28'hFFFFFFF, 3'b100});
    end
    v1 = 1'b1; d1 = 16'h1234;
    tick();
    rst1 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy1 || done1 || !rdy1 || {h1_3, h1_2, h1_1, h1_0} !== 28'hFFFFFFF) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL post_reset_quiet got %0d bad cycles exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    drain(40);
    test_blanking();
    test_err();
    test_back_to_back();
    test_reset_mid();
    drain(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
